// File: rtl/cva6_ras_ckpt_if.sv
// rtl/cva6_ras_ckpt_if.sv - request/response bundle between the frontend and the return-address stack
interface cva6_ras_ckpt_if #(
  parameter int VLEN    = 64,
  parameter int NR_CKPT = 4
);
  localparam int CKW = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1;

  logic            flush_i;
  logic            push_i;
  logic            pop_i;
  logic [VLEN-1:0] data_i;
  logic [VLEN-1:0] data_o;
  logic            valid_o;
  logic            ckpt_i;
  logic            ckpt_ready_o;
  logic [CKW-1:0]  ckpt_id_o;
  logic            restore_i;
  logic [CKW-1:0]  restore_id_i;
  logic            release_i;
  logic [CKW-1:0]  release_id_i;

  modport master (
    output flush_i, push_i, pop_i, data_i, ckpt_i, restore_i, restore_id_i, release_i, release_id_i,
    input  data_o, valid_o, ckpt_ready_o, ckpt_id_o
  );

  modport slave (
    input  flush_i, push_i, pop_i, data_i, ckpt_i, restore_i, restore_id_i, release_i, release_id_i,
    output data_o, valid_o, ckpt_ready_o, ckpt_id_o
  );
endinterface

// File: rtl/cva6_ras_ckpt.sv
// rtl/cva6_ras_ckpt.sv - return-address stack with speculative checkpoint/restore
module cva6_ras_ckpt #(
  parameter int DEPTH   = 8,
  parameter int VLEN    = 64,
  parameter int NR_CKPT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  cva6_ras_ckpt_if.slave      ras
);
  localparam int TW  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CKW = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1;
  localparam logic [TW-1:0] TOS_LAST = TW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // architectural stack state
  logic [VLEN-1:0]    entries [DEPTH];
  logic [TW-1:0]      tos;
  logic [CW-1:0]      cnt;

  // checkpoint slots: a snapshot of tos, cnt and the top entry
  logic [NR_CKPT-1:0] busy;
  logic [TW-1:0]      s_tos [NR_CKPT];
  logic [CW-1:0]      s_cnt [NR_CKPT];
  logic [VLEN-1:0]    s_top [NR_CKPT];

  logic [TW-1:0]      tos_inc;
  logic [TW-1:0]      tos_dec;
  logic [CKW-1:0]     free_id;
  logic               any_free;
  logic               snap_en;
  logic [TW-1:0]      tos_n;
  logic [CW-1:0]      cnt_n;
  logic [NR_CKPT-1:0] busy_n;
  logic               wr_en;
  logic [TW-1:0]      wr_idx;
  logic [VLEN-1:0]    wr_data;

  // circular neighbours of tos; explicit compare so DEPTH need not be a power of two
  always_comb begin
    tos_inc = (tos == TOS_LAST) ? '0 : tos + TW'(1);
    tos_dec = (tos == '0) ? TOS_LAST : tos - TW'(1);
  end

  // lowest free checkpoint slot, scanned from the top so the lowest index wins
  always_comb begin
    free_id = '0;
    for (int i = NR_CKPT - 1; i >= 0; i--) begin
      if (!busy[i]) free_id = CKW'(i);
    end
    any_free = |(~busy);
  end

  assign ras.data_o       = entries[tos];
  assign ras.valid_o      = (cnt != '0);
  assign ras.ckpt_ready_o = any_free;
  assign ras.ckpt_id_o    = free_id;

  // next stack/slot state: flush beats restore, restore beats push/pop and ckpt
  always_comb begin
    tos_n   = tos;
    cnt_n   = cnt;
    busy_n  = busy;
    wr_en   = 1'b0;
    wr_idx  = tos;
    wr_data = ras.data_i;
    snap_en = 1'b0;
    if (ras.flush_i) begin
      tos_n  = '0;
      cnt_n  = '0;
      busy_n = '0;
    end else if (ras.restore_i) begin
      tos_n   = s_tos[ras.restore_id_i];
      cnt_n   = s_cnt[ras.restore_id_i];
      wr_en   = 1'b1;
      wr_idx  = s_tos[ras.restore_id_i];
      wr_data = s_top[ras.restore_id_i];
      busy_n  = '0;
    end else begin
      if (ras.push_i && ras.pop_i) begin
        // replace the top in place; an empty stack becomes one deep
        wr_en = 1'b1;
        if (cnt == '0) cnt_n = CW'(1);
      end else if (ras.push_i) begin
        // overflow wraps onto the oldest entry
        wr_en  = 1'b1;
        wr_idx = tos_inc;
        tos_n  = tos_inc;
        cnt_n  = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);
      end else if (ras.pop_i && (cnt != '0)) begin
        tos_n = tos_dec;
        cnt_n = cnt - CW'(1);
      end
      snap_en = ras.ckpt_i && any_free;
      // release first so allocating a slot that was named by a stale release still sticks
      if (ras.release_i) busy_n[ras.release_id_i] = 1'b0;
      if (snap_en) busy_n[free_id] = 1'b1;
    end
  end

  // state registers; snapshots capture the pre-update stack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      for (int j = 0; j < NR_CKPT; j++) begin
        s_tos[j] <= '0;
        s_cnt[j] <= '0;
        s_top[j] <= '0;
      end
      tos  <= '0;
      cnt  <= '0;
      busy <= '0;
    end else begin
      tos  <= tos_n;
      cnt  <= cnt_n;
      busy <= busy_n;
      if (wr_en) entries[wr_idx] <= wr_data;
      if (snap_en) begin
        s_tos[free_id] <= tos;
        s_cnt[free_id] <= cnt;
        s_top[free_id] <= entries[tos];
      end
    end
  end
endmodule
